// File: rtl/leak_pkg.sv
// Shared types and widths for the leak scheduler and its multiplier datapath.
package leak_pkg;
    localparam int LEAK_DATA_W = 8;
    localparam int LEAK_PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        FIN
    } leak_state_t;
endpackage

// File: rtl/leak_scheduler_if.sv
// Membrane memory port shared between the leak scheduler (master) and the memory/integrator side (slave).
interface leak_scheduler_if #(
    parameter int ADDR_W = 8
);
    import leak_pkg::*;

    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_rd_en;
    logic [LEAK_DATA_W-1:0] mem_rd_data;
    logic                   mem_wr_en;
    logic [LEAK_DATA_W-1:0] mem_wr_data;
    logic                   hold;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  mem_rd_data, hold
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output mem_rd_data, hold
    );
endinterface

// File: rtl/leak_unit.sv
// Leak multiplier: unsigned 8x8 product, high byte kept, low byte truncated (no rounding).
module leak_unit
    import leak_pkg::*;
(
    input  logic [LEAK_DATA_W-1:0] membrane_potential,
    input  logic [LEAK_DATA_W-1:0] leak_weight,
    output logic [LEAK_DATA_W-1:0] leak_output
);
    logic [LEAK_PROD_W-1:0] prod;

    assign prod        = LEAK_PROD_W'(membrane_potential) * LEAK_PROD_W'(leak_weight);
    assign leak_output = LEAK_DATA_W'(prod >> LEAK_DATA_W);
endmodule

// File: rtl/leak_scheduler.sv
// Per-tick leak sweep over all neurons with read-modify-write through one shared leak_unit.
// Define LEAK_OVERRUN_CNT_EN to build the saturating ignored-tick counter behind overrun_cnt.
module leak_scheduler
    import leak_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] leak_weight,
    leak_scheduler_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    leak_state_t       state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [DATA_W-1:0] wgt_reg;
    logic [DATA_W-1:0] mp_reg;
    logic              overrun_reg;
    logic [DATA_W-1:0] leaked;
    logic              rd_en;
    logic              wr_en;
    logic              tick_ignored;

    // Any tick outside IDLE (FIN included) is dropped, never restarts the sweep.
    assign tick_ignored = tick && (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            wgt_reg     <= '0;
            mp_reg      <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (tick_ignored)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        wgt_reg   <= leak_weight;
                        idx_reg   <= '0;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    if (!mem.hold)
                        state_reg <= WAIT;
                end
                WAIT: begin
                    mp_reg    <= mem.mem_rd_data;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= FIN;
                    end else begin
                        idx_reg   <= idx_reg + ADDR_W'(1);
                        state_reg <= READ;
                    end
                end
                FIN:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    leak_unit u_leak_unit (
        .membrane_potential (mp_reg),
        .leak_weight        (wgt_reg),
        .leak_output        (leaked)
    );

    // The integrator gets the memory only between neurons, so hold gates just the read.
    assign rd_en = (state_reg == READ) && !mem.hold;
    assign wr_en = (state_reg == WRITE);

    assign mem.mem_rd_en   = rd_en;
    assign mem.mem_wr_en   = wr_en;
    assign mem.mem_addr    = (rd_en || wr_en) ? idx_reg : '0;
    assign mem.mem_wr_data = wr_en ? leaked : '0;

    assign busy    = (state_reg == READ) || (state_reg == WAIT) || (state_reg == WRITE);
    assign done    = (state_reg == FIN);
    assign overrun = overrun_reg;

`ifdef LEAK_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            ovr_cnt_reg <= '0;
        else if (tick_ignored && (ovr_cnt_reg != 8'hFF))
            ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
    end

    assign overrun_cnt = ovr_cnt_reg;
`else
    assign overrun_cnt = '0;
`endif
endmodule
